// File: rtl/sobel_pkg.sv
// sobel_pkg: shared defaults, coordinate width and FSM encoding for the Sobel line buffer
package sobel_pkg;
  localparam int DEF_PIX_W = 8;
  localparam int DEF_IMG_WIDTH = 16;
  localparam int DEF_IMG_HEIGHT = 16;
  localparam int COORD_W = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
endpackage

// File: rtl/sobel_if.sv
// sobel_if: pixel stream in, 3-pixel column stream out
interface sobel_if
  import sobel_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
) ();
  logic [PIX_W-1:0] pix_in;
  logic pix_valid;
  logic sof;
  logic [PIX_W-1:0] pixel_out1;
  logic [PIX_W-1:0] pixel_out2;
  logic [PIX_W-1:0] pixel_out3;
  logic start;
  logic [COORD_W-1:0] col_x;
  logic [COORD_W-1:0] row_y;
  logic frame_done;
  modport master (
    output pix_in, pix_valid, sof,
    input pixel_out1, pixel_out2, pixel_out3, start, col_x, row_y, frame_done
  );
  modport slave (
    input pix_in, pix_valid, sof,
    output pixel_out1, pixel_out2, pixel_out3, start, col_x, row_y, frame_done
  );
endinterface

// File: rtl/sobel_line_buffer_line_ram.sv
// line_ram: one image line, combinational read and synchronous write at the same address
module line_ram #(
  parameter int DEPTH = 16,
  parameter int W = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  assign o_rdata = r_mem[i_addr];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
endmodule

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: buffers two image lines and emits one vertical 3-pixel column per accepted pixel
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int PIX_W = DEF_PIX_W
) (
  input logic clk,
  input logic rst,
  sobel_if.slave bus
);
  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_HEIGHT - 1);
  logic [1:0] r_state, w_next;
  logic [COORD_W-1:0] r_x, r_y, w_cx, w_cy, w_nx, w_ny, r_cx, r_ry;
  logic [PIX_W-1:0] w_rd_a, w_rd_b, r_p1, r_p2, r_p3;
  logic w_acc, w_emit, w_last_x, w_fill_end, w_frame_end, r_start, r_done;
  // a pixel carrying sof always restarts the frame at (0,0)
  always_comb begin
    w_acc = bus.pix_valid && ((r_state == S_IDLE) ? bus.sof : (r_state != S_DONE));
    w_cx = bus.sof ? '0 : r_x;
    w_cy = bus.sof ? '0 : r_y;
    w_emit = w_acc && (r_state == S_STREAM) && !bus.sof;
    w_last_x = (w_cx == X_LAST);
    w_nx = w_last_x ? '0 : w_cx + 1'b1;
    w_ny = w_last_x ? w_cy + 1'b1 : w_cy;
    w_fill_end = (r_state == S_FILL) && !bus.sof && w_last_x && (w_cy == COORD_W'(1));
    w_frame_end = w_emit && w_last_x && (w_cy == Y_LAST);
    w_next = (r_state == S_DONE) ? S_IDLE :
             !w_acc ? r_state :
             bus.sof ? S_FILL :
             w_fill_end ? S_STREAM :
             w_frame_end ? S_DONE : r_state;
  end
  line_ram #(.DEPTH(IMG_WIDTH), .W(PIX_W), .AW(AW)) u_line_a (
    .clk(clk), .i_we(w_acc), .i_addr(w_cx[AW-1:0]), .i_wdata(bus.pix_in), .o_rdata(w_rd_a)
  );
  line_ram #(.DEPTH(IMG_WIDTH), .W(PIX_W), .AW(AW)) u_line_b (
    .clk(clk), .i_we(w_acc), .i_addr(w_cx[AW-1:0]), .i_wdata(w_rd_a), .o_rdata(w_rd_b)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= S_IDLE;
      r_x <= '0;
      r_y <= '0;
      r_p1 <= '0;
      r_p2 <= '0;
      r_p3 <= '0;
      r_cx <= '0;
      r_ry <= '0;
      r_start <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_start <= w_emit;
      r_done <= w_frame_end;
      if (w_acc) begin
        r_x <= w_nx;
        r_y <= w_ny;
      end else if (r_state == S_DONE) begin
        r_x <= '0;
        r_y <= '0;
      end
      if (w_emit) begin
        r_p1 <= w_rd_b;
        r_p2 <= w_rd_a;
        r_p3 <= bus.pix_in;
        r_cx <= w_cx;
        r_ry <= w_cy;
      end
    end
  assign bus.pixel_out1 = r_p1;
  assign bus.pixel_out2 = r_p2;
  assign bus.pixel_out3 = r_p3;
  assign bus.col_x = r_cx;
  assign bus.row_y = r_ry;
  assign bus.start = r_start;
  assign bus.frame_done = r_done;
endmodule

// File: doc/sobel_line_buffer.md
Name: sobel_line_buffer

Overview:
- Upstream feeder for the Sobel edge stage.
- Accepts a raster-scan pixel stream, one pixel per accepted cycle, and stores the two previous image lines.
- Emits one 3-pixel vertical column per accepted pixel once two full lines are buffered. This is the column-per-clock format the edge stage consumes on its three pixel inputs, qualified by its start enable.

Parameters:
- IMG_WIDTH, 16, pixels per line (2..256).
- IMG_HEIGHT, 16, lines per frame (3..256).
- PIX_W, 8, bits per pixel.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_in  in  PIX_W  incoming pixel, raster order.
- pix_valid  in  1  pix_in valid this cycle. Always accepted; no backpressure.
- sof  in  1  start of frame. Qualified by pix_valid; marks the pixel at (0,0).
- pixel_out1  out  PIX_W  column pixel from row y-2 (top).
- pixel_out2  out  PIX_W  column pixel from row y-1 (middle).
- pixel_out3  out  PIX_W  column pixel from row y (bottom, current input).
- start  out  1  column valid; drives the edge stage enable.
- col_x  out  8  x of emitted column.
- row_y  out  8  y of bottom row of emitted column.
- frame_done  out  1  one-cycle pulse after the last column of a frame.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, x=y=0.
  - All outputs 0: pixel_out1/2/3, start, col_x, row_y, frame_done.
  - Line storage is not cleared; outputs are gated until the buffer is filled.
- Line storage: two arrays, lineA (row y-1) and lineB (row y-2), IMG_WIDTH x PIX_W each.
- Read-before-write on each accepted pixel at column x:
  - lineB[x] <= lineA[x].
  - lineA[x] <= pix_in.
- Output latency is 1 cycle. On an accepted pixel (x,y) with y>=2, the next cycle shows:
  - pixel_out1 = old lineB[x], pixel_out2 = old lineA[x], pixel_out3 = pix_in.
  - start = 1, col_x = x, row_y = y.
- Otherwise start=0 the next cycle, and pixel_out*/col_x/row_y hold their last values.
- Counters:
  - x increments per accepted pixel.
  - At x=IMG_WIDTH-1: x wraps to 0 and y increments.
  - Arithmetic is modulo the counter width; no overflow is possible within parameter bounds.
- State machine:
  - IDLE: pix_valid without sof is dropped. pix_valid&sof -> accept as (0,0), go to FILL.
  - FILL (y<2): accept pixels, start=0. When y becomes 2, go to STREAM.
  - STREAM: accept pixels, emit columns. Accepting (IMG_WIDTH-1, IMG_HEIGHT-1) -> DONE.
  - DONE: one cycle. frame_done=1 in this cycle, which coincides with start=1 for the last column. Inputs are ignored. Return to IDLE.
- Gaps: pix_valid=0 cycles stall counters and storage; start=0 in the following cycle.
- sof during FILL/STREAM with pix_valid: abandon the frame.
  - Accept the pixel as (0,0), go to FILL.
  - No frame_done; no column is emitted for that pixel.
- sof without pix_valid: ignored.
- rst mid-frame: immediate return to the reset state. The next frame requires sof.
- frame_done and start are never asserted in FILL or IDLE.

Decomposition:
- Package sobel_pkg:
  - PIX_W, IMG_WIDTH, IMG_HEIGHT defaults.
  - Coordinate width constant (8).
  - State encoding IDLE/FILL/STREAM/DONE.
- One sub-module, line_ram: single-line storage of IMG_WIDTH x PIX_W.
  - Combinational read, synchronous write, same address.
  - Instantiated twice (lineA, lineB).

Test Plan:
- Reset: hold rst 3 cycles with random pix_valid/sof -> all outputs 0, no start, no frame_done.
- Ramp frame 16x16, pixel = (x+16*y) mod 256, continuous pix_valid, sof on the first pixel:
  - start stays 0 for the first 32 pixels.
  - Cycle after input (5,2): pixel_out1=5, pixel_out2=21, pixel_out3=37, col_x=5, row_y=2.
  - Exactly 224 start pulses, then frame_done=1 once after column (15,15).
- Same ramp with pix_valid toggling 1/0 -> identical column sequence, start only in cycles following accepted pixels.
- Second sof at pixel (7,4) of the ramp frame:
  - No frame_done.
  - After that sof, the first start occurs after 32 more pixels, with pixel_out1 taken from the new frame's row 0.
- rst asserted at (3,9) for 1 cycle, then a full frame -> the new frame behaves exactly like the clean ramp case.
- pix_valid without sof in IDLE (10 pixels), then a normal frame -> the 10 pixels are ignored; the first column appears at (0,2) of the new frame.
